sbh_cg_controller: RTL and testbench

SBH_CG_CONTROLLER -- requirements
Module: sbh_cg_controller

---
 rtl/sbh_pkg.sv | 33 +++
 rtl/sbh_nz_tracker.sv | 69 ++++++
 rtl/sbh_cg_controller.sv | 185 ++++++++++++++++++
 tb/tb_sbh_cg_controller.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbh_pkg.sv
// rtl/sbh_pkg.sv - shared FSM encoding, defaults and decision record for the CG sign-hiding controller
package sbh_pkg;

  // Controller FSM encoding; the top mirrors these as logic [2:0] constants.
  typedef enum logic [2:0] {
    SBH_IDLE  = 3'd0,
    SBH_LOAD  = 3'd1,
    SBH_START = 3'd2,
    SBH_WAIT  = 3'd3,
    SBH_OUT   = 3'd4
  } sbh_state_e;

  localparam int SBH_CG_SIZE_DEF = 16;
  localparam int SBH_THRESH_DEF  = 4;
  localparam int SBH_WDOG_LIMIT  = 48;

  // One sign-hiding decision, held on the dec_* outputs until accepted.
  typedef struct packed {
    logic       sbh_en;
    logic       parity;
    logic [3:0] first_nz;
    logic [3:0] last_nz;
    logic       sign_first;
    logic       all_zero;
    logic       err;
  } sbh_dec_t;

  // Span between the outermost nonzero positions; only meaningful when the CG is not all zero.
  function automatic logic [3:0] sbh_nz_dist(input logic [3:0] first_nz, input logic [3:0] last_nz);
    return last_nz - first_nz;
  endfunction

endpackage

// File: rtl/sbh_nz_tracker.sv
// rtl/sbh_nz_tracker.sv - tracks first/last nonzero position and first-nonzero sign over one CG
module sbh_nz_tracker
  import sbh_pkg::*;
#(
  parameter int COEFF_W = 16,
  parameter int CG_SIZE = SBH_CG_SIZE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               beat_i,
  input  logic [3:0]         index_i,
  input  logic [COEFF_W-1:0] coef_i,
  input  logic               clear_i,
  output logic [3:0]         first_nz_o,
  output logic [3:0]         last_nz_o,
  output logic               sign_first_o,
  output logic               all_zero_o
);

  localparam logic [3:0] LAST_IDX = 4'(CG_SIZE - 1);

  logic       found_q, found_d;
  logic [3:0] first_q, first_d;
  logic [3:0] last_q,  last_d;
  logic       sign_q,  sign_d;

  // Coefficients arrive in ascending index order, so the first hit fixes firstNZ and every hit moves lastNZ.
  always_comb begin
    found_d = found_q;
    first_d = first_q;
    last_d  = last_q;
    sign_d  = sign_q;
    if (clear_i) begin
      found_d = 1'b0;
      first_d = '0;
      last_d  = '0;
      sign_d  = 1'b0;
    end else if (beat_i && (coef_i != '0)) begin
      if (!found_q) begin
        first_d = index_i;
        sign_d  = coef_i[COEFF_W-1];
      end
      found_d = 1'b1;
      last_d  = index_i;
    end
  end

  // Tracker state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      found_q <= 1'b0;
      first_q <= '0;
      last_q  <= '0;
      sign_q  <= 1'b0;
    end else begin
      found_q <= found_d;
      first_q <= first_d;
      last_q  <= last_d;
      sign_q  <= sign_d;
    end
  end

  // An empty CG reports an inverted range so the datapath sums nothing.
  assign all_zero_o   = !found_q;
  assign first_nz_o   = found_q ? first_q : LAST_IDX;
  assign last_nz_o    = found_q ? last_q  : 4'd0;
  assign sign_first_o = found_q & sign_q;

endmodule

// File: rtl/sbh_cg_controller.sv
// rtl/sbh_cg_controller.sv - CG sign-hiding decision controller; define SBH_TIMEOUT_EN for the WAIT watchdog
module sbh_cg_controller
  import sbh_pkg::*;
#(
  parameter int COEFF_W    = 16,
  parameter int CG_SIZE    = SBH_CG_SIZE_DEF,
  parameter int SBH_THRESH = SBH_THRESH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COEFF_W-1:0] in_coef,
  output logic               sum_valid_in,
  output logic [COEFF_W-1:0] sum_coef,
  output logic [3:0]         sum_index,
  output logic               sum_load_done,
  output logic               sum_start_calc,
  output logic [3:0]         sum_first_nz,
  output logic [3:0]         sum_last_nz,
  input  logic [19:0]        sum_abs,
  input  logic               sum_parity,
  input  logic               sum_valid_out,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic               dec_sbh_en,
  output logic               dec_parity,
  output logic [3:0]         dec_first_nz,
  output logic [3:0]         dec_last_nz,
  output logic               dec_sign_first,
  output logic               dec_all_zero,
  output logic               dec_err
);

  localparam logic [2:0] ST_IDLE  = SBH_IDLE;
  localparam logic [2:0] ST_LOAD  = SBH_LOAD;
  localparam logic [2:0] ST_START = SBH_START;
  localparam logic [2:0] ST_WAIT  = SBH_WAIT;
  localparam logic [2:0] ST_OUT   = SBH_OUT;

  localparam logic [3:0] LAST_IDX = 4'(CG_SIZE - 1);
  localparam logic [3:0] THRESH_4 = 4'(SBH_THRESH);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  sbh_dec_t    dec_q,   dec_d;
  logic [19:0] abs_q,   abs_d;

`ifdef SBH_TIMEOUT_EN
  localparam logic [5:0] WDOG_LAST = 6'(SBH_WDOG_LIMIT - 1);
  logic [5:0] wdog_q, wdog_d;
`endif

  logic       beat;
  logic       last_beat;
  logic       handshake;
  logic       range_live;
  logic [3:0] trk_first;
  logic [3:0] trk_last;
  logic       trk_sign;
  logic       trk_all_zero;
  logic [3:0] nz_dist;
  logic       sbh_en_calc;

  assign in_ready   = (state_q == ST_LOAD);
  assign beat       = in_ready && in_valid;
  assign last_beat  = beat && (cnt_q == LAST_IDX);
  assign handshake  = (state_q == ST_OUT) && dec_ready;
  assign range_live = (state_q == ST_START) || (state_q == ST_WAIT);

  sbh_nz_tracker #(
    .COEFF_W (COEFF_W),
    .CG_SIZE (CG_SIZE)
  ) u_nz_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .beat_i       (beat),
    .index_i      (cnt_q),
    .coef_i       (in_coef),
    .clear_i      (handshake),
    .first_nz_o   (trk_first),
    .last_nz_o    (trk_last),
    .sign_first_o (trk_sign),
    .all_zero_o   (trk_all_zero)
  );

  assign nz_dist     = sbh_nz_dist(trk_first, trk_last);
  assign sbh_en_calc = !trk_all_zero && (nz_dist >= THRESH_4);

  // Next-state, load counter and decision capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    abs_d   = abs_q;
`ifdef SBH_TIMEOUT_EN
    wdog_d  = (state_q == ST_WAIT) ? wdog_q + 6'd1 : 6'd0;
`endif
    case (state_q)
      ST_IDLE: state_d = ST_LOAD;
      ST_LOAD: begin
        if (beat) begin
          cnt_d = last_beat ? 4'd0 : cnt_q + 4'd1;
          if (last_beat) state_d = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (sum_valid_out) begin
          abs_d            = sum_abs;
          dec_d.sbh_en     = sbh_en_calc;
          dec_d.parity     = sum_parity;
          dec_d.first_nz   = trk_first;
          dec_d.last_nz    = trk_last;
          dec_d.sign_first = trk_sign;
          dec_d.all_zero   = trk_all_zero;
          dec_d.err        = 1'b0;
          state_d          = ST_OUT;
        end
`ifdef SBH_TIMEOUT_EN
        else if (wdog_q == WDOG_LAST) begin
          abs_d            = '0;
          dec_d.sbh_en     = 1'b0;
          dec_d.parity     = 1'b0;
          dec_d.first_nz   = trk_first;
          dec_d.last_nz    = trk_last;
          dec_d.sign_first = trk_sign;
          dec_d.all_zero   = trk_all_zero;
          dec_d.err        = 1'b1;
          state_d          = ST_OUT;
        end
`endif
      end
      ST_OUT: begin
        if (dec_ready) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dec_q   <= '0;
      abs_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      abs_q   <= abs_d;
    end
  end

`ifdef SBH_TIMEOUT_EN
  // Watchdog counts WAIT cycles and restarts whenever the FSM leaves WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`endif

  // absSum is kept for debug probing; only its parity leaves the block.
  logic abs_unused;
  assign abs_unused = ^abs_q;

  assign sum_valid_in   = beat;
  assign sum_coef       = beat ? in_coef : '0;
  assign sum_index      = cnt_q;
  assign sum_load_done  = last_beat;
  assign sum_start_calc = (state_q == ST_START);
  assign sum_first_nz   = range_live ? trk_first : 4'd0;
  assign sum_last_nz    = range_live ? trk_last  : 4'd0;

  assign dec_valid      = (state_q == ST_OUT);
  assign dec_sbh_en     = dec_q.sbh_en;
  assign dec_parity     = dec_q.parity;
  assign dec_first_nz   = dec_q.first_nz;
  assign dec_last_nz    = dec_q.last_nz;
  assign dec_sign_first = dec_q.sign_first;
  assign dec_all_zero   = dec_q.all_zero;
  assign dec_err        = dec_q.err;

endmodule

// File: tb/tb_sbh_cg_controller.sv
// tb/tb_sbh_cg_controller.sv - scoreboard bench for sbh_cg_controller with a behavioural abs-sum datapath
module tb_sbh_cg_controller;

  localparam int DP_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_coef;
  logic        sum_valid_in;
  logic [15:0] sum_coef;
  logic [3:0]  sum_index;
  logic        sum_load_done;
  logic        sum_start_calc;
  logic [3:0]  sum_first_nz;
  logic [3:0]  sum_last_nz;
  logic [19:0] sum_abs;
  logic        sum_parity;
  logic        sum_valid_out;
  logic        dec_valid;
  logic        dec_ready;
  logic        dec_sbh_en;
  logic        dec_parity;
  logic [3:0]  dec_first_nz;
  logic [3:0]  dec_last_nz;
  logic        dec_sign_first;
  logic        dec_all_zero;
  logic        dec_err;

  always #5 clk = ~clk;

  sbh_cg_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_coef        (in_coef),
    .sum_valid_in   (sum_valid_in),
    .sum_coef       (sum_coef),
    .sum_index      (sum_index),
    .sum_load_done  (sum_load_done),
    .sum_start_calc (sum_start_calc),
    .sum_first_nz   (sum_first_nz),
    .sum_last_nz    (sum_last_nz),
    .sum_abs        (sum_abs),
    .sum_parity     (sum_parity),
    .sum_valid_out  (sum_valid_out),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_sbh_en     (dec_sbh_en),
    .dec_parity     (dec_parity),
    .dec_first_nz   (dec_first_nz),
    .dec_last_nz    (dec_last_nz),
    .dec_sign_first (dec_sign_first),
    .dec_all_zero   (dec_all_zero),
    .dec_err        (dec_err)
  );

  typedef struct {
    logic [12:0] dec;
    int          lat;
    int          abs_sum;
  } exp_t;

  exp_t        exp_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  int          ld_cyc = 0;
  logic        prev_dv = 1'b0;
  logic        dp_en = 1'b1;
  logic        stray_req = 1'b0;
  logic [15:0] cg_buf[16];
  logic [15:0] dp_mem[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
  endtask

  // {sbh_en, parity, first_nz, last_nz, sign_first, all_zero, err}
  function automatic logic [12:0] dvec(input logic s, input logic p, input logic [3:0] f,
                                       input logic [3:0] l, input logic sg, input logic az,
                                       input logic er);
    return {s, p, f, l, sg, az, er};
  endfunction

  task automatic expect_cg(input logic [12:0] d, input int lat, input int abs_sum);
    exp_t e;
    e.dec = d;
    e.lat = lat;
    e.abs_sum = abs_sum;
    exp_q.push_back(e);
  endtask

  task automatic clear_buf();
    for (int i = 0; i < 16; i++) cg_buf[i] = 16'd0;
  endtask

  task automatic send_cg(input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      int w;
      w = 0;
      in_valid = 1'b1;
      in_coef  = cg_buf[i];
      @(negedge clk);
      while (!in_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_coef  = 16'd0;
  endtask

  task automatic wait_drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_flags"}, {22'd0, in_ready, sum_valid_in, sum_load_done, sum_start_calc,
        dec_valid, dec_err, dec_sbh_en, dec_parity, dec_all_zero, dec_sign_first}, 32'd0);
    chk({name, "_fields"}, {12'd0, sum_index, sum_first_nz, sum_last_nz, dec_first_nz, dec_last_nz},
        32'd0);
    chk({name, "_coef"}, {16'd0, sum_coef}, 32'd0);
  endtask

  // Behavioural abs-sum datapath: stores writes, sums |coef| over the range, answers DP_LAT cycles later.
  initial begin : dp_stub
    int   cd;
    int   acc;
    int   a;
    logic stray_seen;
    cd = 0;
    stray_seen = 1'b0;
    sum_valid_out = 1'b0;
    sum_abs = 20'd0;
    sum_parity = 1'b0;
    forever begin
      @(negedge clk);
      sum_valid_out = 1'b0;
      if (!rst_n) begin
        cd = 0;
        continue;
      end
      if (sum_valid_in) dp_mem[sum_index] = sum_coef;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && dp_en) sum_valid_out = 1'b1;
      end else if (stray_req && !stray_seen) begin
        sum_valid_out = 1'b1;
        sum_abs = 20'd7;
        sum_parity = 1'b1;
        stray_seen = 1'b1;
      end
      if (!stray_req) stray_seen = 1'b0;
      if (sum_start_calc) begin
        acc = 0;
        for (int i = int'(sum_first_nz); i <= int'(sum_last_nz); i++) begin
          a = int'($signed(dp_mem[i]));
          acc += (a < 0) ? -a : a;
        end
        sum_abs = 20'(acc);
        sum_parity = acc[0];
        cd = DP_LAT;
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_start first=%0d last=%0d", sum_first_nz, sum_last_nz);
        end else begin
          chk("start_range", {24'd0, sum_first_nz, sum_last_nz},
              {24'd0, exp_q[0].dec[10:7], exp_q[0].dec[6:3]});
          chk("abs_sum", 32'(acc), 32'(exp_q[0].abs_sum));
        end
      end
    end
  end

  // Decision monitor: checks every presented decision against the front expectation, pops on handshake.
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_dv = 1'b0;
        continue;
      end
      if (in_valid && in_ready && sum_load_done) ld_cyc = cyc;
      if (dec_valid) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_decision dec=0x%0h", {dec_sbh_en, dec_parity, dec_first_nz,
                   dec_last_nz, dec_sign_first, dec_all_zero, dec_err});
        end else begin
          if (!prev_dv) chk("latency", 32'(cyc - ld_cyc), 32'(exp_q[0].lat));
          chk("decision", {19'd0, dec_sbh_en, dec_parity, dec_first_nz, dec_last_nz,
              dec_sign_first, dec_all_zero, dec_err}, {19'd0, exp_q[0].dec});
          chk("in_ready_low_in_out", 32'(in_ready), 32'd0);
          if (dec_ready) void'(exp_q.pop_front());
        end
      end
      prev_dv = dec_valid;
    end
  end

  initial begin : global_guard
    #2000000;
    $display("FAIL global_timeout total=%0d passed=%0d", total_cnt, pass_cnt);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int w;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_coef = 16'd0;
    dec_ready = 1'b1;
    clear_buf();
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("load_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // +3 at 2, -5 at 9: span 7, |sum| 8
    clear_buf();
    cg_buf[2] = 16'sd3;
    cg_buf[9] = -16'sd5;
    expect_cg(dvec(1'b1, 1'b0, 4'd2, 4'd9, 1'b0, 1'b0, 1'b0), 2 + DP_LAT, 8);
    send_cg(16);
    wait_drain("cg_a");

    // -1 at 4, +2 at 6: span 2, |sum| 3
    clear_buf();
    cg_buf[4] = -16'sd1;
    cg_buf[6] = 16'sd2;
    expect_cg(dvec(1'b0, 1'b1, 4'd4, 4'd6, 1'b1, 1'b0, 1'b0), 2 + DP_LAT, 3);
    send_cg(16);
    wait_drain("cg_b");

    // all zero
    clear_buf();
    expect_cg(dvec(1'b0, 1'b0, 4'd15, 4'd0, 1'b0, 1'b1, 1'b0), 2 + DP_LAT, 0);
    send_cg(16);
    wait_drain("cg_zero");

    // +1 at 0 and 15, stray result pulse during load, decision held for 10 cycles
    clear_buf();
    cg_buf[0] = 16'sd1;
    cg_buf[15] = 16'sd1;
    dec_ready = 1'b0;
    expect_cg(dvec(1'b1, 1'b0, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0), 2 + DP_LAT, 2);
    stray_req = 1'b1;
    send_cg(16);
    stray_req = 1'b0;
    w = 0;
    while (!dec_valid && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("hold_dec_valid_seen", 32'(dec_valid), 32'd1);
    // -7 at 3, +4 at 7: span equals threshold
    clear_buf();
    cg_buf[3] = -16'sd7;
    cg_buf[7] = 16'sd4;
    in_valid = 1'b1;
    in_coef = cg_buf[0];
    repeat (10) @(posedge clk);
    #1;
    dec_ready = 1'b1;
    expect_cg(dvec(1'b1, 1'b1, 4'd3, 4'd7, 1'b1, 1'b0, 1'b0), 2 + DP_LAT, 11);
    send_cg(16);
    wait_drain("cg_hold");

    // partial CG aborted by reset
    clear_buf();
    cg_buf[1] = -16'sd9;
    cg_buf[3] = 16'sd5;
    send_cg(7);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // +2 at 5 and 8: span one below threshold
    clear_buf();
    cg_buf[5] = 16'sd2;
    cg_buf[8] = 16'sd2;
    expect_cg(dvec(1'b0, 1'b0, 4'd5, 4'd8, 1'b0, 1'b0, 1'b0), 2 + DP_LAT, 4);
    send_cg(16);
    wait_drain("cg_after_reset");

    // single -1 at the last index
    clear_buf();
    cg_buf[15] = -16'sd1;
    expect_cg(dvec(1'b0, 1'b1, 4'd15, 4'd15, 1'b1, 1'b0, 1'b0), 2 + DP_LAT, 1);
    send_cg(16);
    wait_drain("cg_last_only");

`ifdef SBH_TIMEOUT_EN
    // datapath silent: watchdog must deliver an error decision 49 cycles after START
    clear_buf();
    cg_buf[1] = 16'sd2;
    cg_buf[10] = 16'sd3;
    dp_en = 1'b0;
    expect_cg(dvec(1'b0, 1'b0, 4'd1, 4'd10, 1'b0, 1'b0, 1'b1), 1 + 49, 5);
    send_cg(16);
    wait_drain("cg_timeout");
    dp_en = 1'b1;
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
